// File: rtl/md_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation
// encodings and FSM state type.
package md_pkg;

    localparam int MD_OP_W = 3;

    localparam logic [MD_OP_W-1:0] MD_MULT  = 3'b000;
    localparam logic [MD_OP_W-1:0] MD_MULTU = 3'b001;
    localparam logic [MD_OP_W-1:0] MD_DIV   = 3'b010;
    localparam logic [MD_OP_W-1:0] MD_DIVU  = 3'b011;
    localparam logic [MD_OP_W-1:0] MD_MTHI  = 3'b100;
    localparam logic [MD_OP_W-1:0] MD_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_FIX  = 2'd2
    } md_state_e;

endpackage

// File: rtl/md_step.sv
// One iteration of the {rem,acc} datapath.
// Multiply: add the multiplicand into rem when acc[0] is set, then shift the
//           pair right by one (product accumulates from the top down).
// Divide:   shift the pair left by one, trial-subtract the divisor from rem,
//           keep the difference and shift a 1 into the quotient when it fits.
module md_step #(
    parameter int XLEN = 32
) (
    input  logic            i_is_div,
    input  logic [XLEN-1:0] i_opd,
    input  logic [XLEN-1:0] i_rem,
    input  logic [XLEN-1:0] i_acc,
    output logic [XLEN-1:0] o_rem,
    output logic [XLEN-1:0] o_acc
);

    logic [XLEN:0]   w_sum;
    logic [XLEN:0]   w_shift;
    logic [XLEN-1:0] w_diff;
    logic            w_ge;

    // Single shift-add or restoring shift-subtract step
    always_comb begin
        w_sum   = {1'b0, i_rem} + (i_acc[0] ? {1'b0, i_opd} : '0);
        w_shift = {i_rem, i_acc[XLEN-1]};
        w_diff  = w_shift[XLEN-1:0] - i_opd;
        w_ge    = (w_shift >= {1'b0, i_opd});
        if (i_is_div) begin
            o_rem = w_ge ? w_diff : w_shift[XLEN-1:0];
            o_acc = {i_acc[XLEN-2:0], w_ge};
        end else begin
            o_rem = w_sum[XLEN:1];
            o_acc = {w_sum[0], i_acc[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/md_iter_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO register pair.
// Optional build macro MD_EARLY_TERM_EN: divide-by-zero and multiply by a
// zero operand skip the iteration phase and complete one edge after accept.
//
// state   | meaning
// --------+------------------------------------------------------------
// MD_IDLE | waiting; accepts requests, MTHI/MTLO write directly
// MD_CALC | XLEN iterations of the shift-add / shift-subtract step
// MD_FIX  | sign correction and HI/LO write; done pulses next cycle
module md_iter_unit
    import md_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [MD_OP_W-1:0] req_op,
    input  logic [XLEN-1:0]    req_a,
    input  logic [XLEN-1:0]    req_b,
    input  logic               flush,
    output logic               busy,
    output logic               done,
    output logic               div_by_zero,
    output logic [XLEN-1:0]    hi,
    output logic [XLEN-1:0]    lo
);

    localparam int CNT_W = $clog2(XLEN + 1);

    md_state_e         r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [XLEN-1:0]   r_hi, r_lo, r_opd, r_rem, r_acc, r_raw_a;
    logic              r_is_div, r_neg_q, r_neg_r, r_dbz, r_done, r_dbz_out;
    logic              w_accept, w_iter, w_is_div, w_signed, w_sa, w_sb;
    logic              w_b_zero, w_skip;
    logic [XLEN-1:0]   w_mag_a, w_mag_b, w_step_rem, w_step_acc, w_quo, w_remd;
    logic [2*XLEN-1:0] w_prod;

    assign req_ready   = (r_state == MD_IDLE) && !flush;
    assign busy        = (r_state != MD_IDLE);
    assign done        = r_done;
    assign div_by_zero = r_dbz_out;
    assign hi          = r_hi;
    assign lo          = r_lo;

    assign w_accept = req_valid && req_ready;
    assign w_iter   = !req_op[2];
    assign w_is_div = (req_op == MD_DIV) || (req_op == MD_DIVU);
    assign w_signed = (req_op == MD_MULT) || (req_op == MD_DIV);
    assign w_sa     = w_signed && req_a[XLEN-1];
    assign w_sb     = w_signed && req_b[XLEN-1];
    // Negating the most negative value yields 2^(XLEN-1) read as unsigned.
    assign w_mag_a  = w_sa ? -req_a : req_a;
    assign w_mag_b  = w_sb ? -req_b : req_b;
    assign w_b_zero = (req_b == '0);

`ifdef MD_EARLY_TERM_EN
    assign w_skip = w_is_div ? w_b_zero : ((req_a == '0) || w_b_zero);
`else
    assign w_skip = 1'b0;
`endif

    assign w_prod = r_neg_q ? -{r_rem, r_acc} : {r_rem, r_acc};
    assign w_quo  = r_neg_q ? -r_acc : r_acc;
    assign w_remd = r_neg_r ? -r_rem : r_rem;

    md_step #(.XLEN(XLEN)) u_step (
        .i_is_div (r_is_div),
        .i_opd    (r_opd),
        .i_rem    (r_rem),
        .i_acc    (r_acc),
        .o_rem    (w_step_rem),
        .o_acc    (w_step_acc)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= MD_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic; flush overrides everything
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            MD_IDLE: if (w_accept && w_iter) w_state_nxt = w_skip ? MD_FIX : MD_CALC;
            MD_CALC: if (r_cnt == CNT_W'(XLEN - 1)) w_state_nxt = MD_FIX;
            MD_FIX:  w_state_nxt = MD_IDLE;
            default: w_state_nxt = MD_IDLE;
        endcase
        if (flush) w_state_nxt = MD_IDLE;
    end

    // Operand latch at accept, then one datapath step per CALC cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opd    <= '0;
            r_rem    <= '0;
            r_acc    <= '0;
            r_raw_a  <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dbz    <= 1'b0;
            r_cnt    <= '0;
        end else if (w_accept && w_iter) begin
            r_opd    <= w_is_div ? w_mag_b : w_mag_a;
            r_acc    <= w_is_div ? w_mag_a : (w_skip ? '0 : w_mag_b);
            r_rem    <= '0;
            r_raw_a  <= req_a;
            r_is_div <= w_is_div;
            r_neg_q  <= w_sa ^ w_sb;
            r_neg_r  <= w_sa;
            r_dbz    <= w_is_div && w_b_zero;
            r_cnt    <= '0;
        end else if (r_state == MD_CALC) begin
            r_rem    <= w_step_rem;
            r_acc    <= w_step_acc;
            r_cnt    <= r_cnt + 1'b1;
        end
    end

    // HI/LO: result write in FIX unless flushed, direct MTHI/MTLO at accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (r_state == MD_FIX && !flush) begin
            if (r_dbz) begin
                r_hi <= r_raw_a;
                r_lo <= '1;
            end else if (r_is_div) begin
                r_hi <= w_remd;
                r_lo <= w_quo;
            end else begin
                r_hi <= w_prod[2*XLEN-1:XLEN];
                r_lo <= w_prod[XLEN-1:0];
            end
        end else if (w_accept && req_op == MD_MTHI) begin
            r_hi <= req_a;
        end else if (w_accept && req_op == MD_MTLO) begin
            r_lo <= req_a;
        end
    end

    // Completion pulses, aligned with the cycle HI/LO show the new result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done    <= 1'b0;
            r_dbz_out <= 1'b0;
        end else begin
            r_done    <= (r_state == MD_FIX) && !flush;
            r_dbz_out <= (r_state == MD_FIX) && !flush && r_dbz;
        end
    end

endmodule

// File: tb/tb_md_iter_unit.sv
module tb_md_iter_unit;
    import md_pkg::*;

    localparam int XLEN = 32;
`ifdef MD_EARLY_TERM_EN
    localparam int SKIP_LAT = 1;
`else
    localparam int SKIP_LAT = XLEN + 1;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req_valid = 1'b0;
    logic             flush = 1'b0;
    logic [2:0]       req_op = '0;
    logic [XLEN-1:0]  req_a = '0;
    logic [XLEN-1:0]  req_b = '0;
    logic             req_ready, busy, done, div_by_zero;
    logic [XLEN-1:0]  hi, lo;

    int checks = 0;
    int errors = 0;

    md_iter_unit #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .flush(flush),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference results from plain wide integer arithmetic
    function automatic void compute(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] h, output logic [31:0] l, output bit dbz);
        longint sa, sb, q, r;
        longint unsigned ua, ub, up, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        dbz = 1'b0;
        h = '0;
        l = '0;
        if (op == MD_MULT) begin
            q = sa * sb;
            h = q[63:32];
            l = q[31:0];
        end else if (op == MD_MULTU) begin
            up = ua * ub;
            h = up[63:32];
            l = up[31:0];
        end else if (b == '0) begin
            h = a;
            l = '1;
            dbz = 1'b1;
        end else if (op == MD_DIV) begin
            q = sa / sb;
            r = sa % sb;
            h = r[31:0];
            l = q[31:0];
        end else begin
            up = ua / ub;
            ur = ua % ub;
            h = ur[31:0];
            l = up[31:0];
        end
    endfunction

    function automatic bit skips(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bit s;
        s = op[1] ? (b == '0) : (a == '0 || b == '0);
`ifdef MD_EARLY_TERM_EN
        return s;
`else
        return s && 1'b0;
`endif
    endfunction

    // Behavioural model: pending result plus edges remaining until it lands
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    bit          m_pend = 0, m_done = 0, m_dbz = 0, p_dbz = 0;
    int          m_left = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hi = '0; m_lo = '0; m_pend = 0; m_done = 0; m_dbz = 0; m_left = 0;
        end else begin
            m_done = 0;
            m_dbz  = 0;
            if (flush) begin
                m_pend = 0;
            end else if (m_pend) begin
                m_left--;
                if (m_left == 0) begin
                    m_pend = 0; m_hi = p_hi; m_lo = p_lo; m_done = 1; m_dbz = p_dbz;
                end
            end else if (req_valid) begin
                if (req_op == MD_MTHI) m_hi = req_a;
                else if (req_op == MD_MTLO) m_lo = req_a;
                else if (!req_op[2]) begin
                    compute(req_op, req_a, req_b, p_hi, p_lo, p_dbz);
                    m_pend = 1;
                    m_left = skips(req_op, req_a, req_b) ? 1 : XLEN + 1;
                end
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (rst_n) begin
            chk("cyc_done", {31'b0, done}, {31'b0, m_done});
            chk("cyc_dbz", {31'b0, div_by_zero}, {31'b0, m_dbz});
            chk("cyc_busy", {31'b0, busy}, {31'b0, m_pend});
            chk("cyc_ready", {31'b0, req_ready}, {31'b0, !m_pend && !flush});
            chk("cyc_hi", hi, m_hi);
            chk("cyc_lo", lo, m_lo);
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        step();
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < 200) begin
            step();
            lat++;
        end
        if (done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s: no done within %0d cycles", name, lat);
        end
    endtask

    task automatic count_dones(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (done === 1'b1) cnt++;
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h1;
            4: return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        int lat, cnt;
        repeat (3) step();
        rst_n = 1'b1;
        #1;
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_done", {31'b0, done}, 32'h0);
        chk("rst_ready", {31'b0, req_ready}, 32'h1);
        step();

        issue(MD_MULT, 32'hFFFF_FFFD, 32'h0000_0007);
        wait_done("mult", lat);
        chk("mult_lat", lat, 33);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFEB);
        step();

        issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("multu", lat);
        chk("multu_hi", hi, 32'hFFFF_FFFE);
        chk("multu_lo", lo, 32'h0000_0001);
        issue(MD_DIVU, 32'd7, 32'd2);
        wait_done("divu_b2b", lat);
        chk("divu_lat", lat, 33);
        chk("divu_lo", lo, 32'd3);
        chk("divu_hi", hi, 32'd1);

        issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done("div_neg", lat);
        chk("div_neg_lo", lo, 32'hFFFF_FFFD);
        chk("div_neg_hi", hi, 32'hFFFF_FFFF);
        issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("div_min", lat);
        chk("div_min_lo", lo, 32'h8000_0000);
        chk("div_min_hi", hi, 32'h0);

        issue(MD_DIV, 32'h1234_5678, 32'h0);
        wait_done("div_zero", lat);
        chk("dbz_lat", lat, SKIP_LAT);
        chk("dbz_flag", {31'b0, div_by_zero}, 32'h1);
        chk("dbz_lo", lo, 32'hFFFF_FFFF);
        chk("dbz_hi", hi, 32'h1234_5678);
        issue(MD_MULTU, 32'h0, 32'h5);
        wait_done("mul_zero", lat);
        chk("mulz_lat", lat, SKIP_LAT);
        chk("mulz_hi", hi, 32'h0);
        chk("mulz_lo", lo, 32'h0);

        issue(MD_MTHI, 32'hAAAA_0000, 32'h0);
        issue(MD_MTLO, 32'h0000_5555, 32'h0);
        issue(MD_MULT, 32'd3, 32'd5);
        repeat (9) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
        chk("flush_ready", {31'b0, req_ready}, 32'h1);
        chk("flush_hi", hi, 32'hAAAA_0000);
        chk("flush_lo", lo, 32'h0000_5555);
        count_dones(40, cnt);
        chk("flush_nodone", cnt, 0);

        req_valid = 1'b1; req_op = MD_DIVU; req_a = 32'd100; req_b = 32'd7;
        step();
        wait_done("held", lat);
        req_valid = 1'b0;
        chk("held_lo", lo, 32'd14);
        chk("held_hi", hi, 32'd2);
        count_dones(40, cnt);
        chk("held_once", cnt, 0);

        for (int i = 0; i < 3000; i++) begin
            req_valid = ($urandom_range(0, 2) != 0);
            req_op    = 3'($urandom_range(0, 7));
            req_a     = pick();
            req_b     = pick();
            flush     = ($urandom_range(0, 49) == 0);
            step();
        end
        req_valid = 1'b0;
        flush = 1'b0;
        repeat (40) step();

        issue(MD_MTHI, 32'hCAFE_0001, 32'h0);
        issue(MD_DIV, 32'd1000, 32'd3);
        repeat (5) step();
        rst_n = 1'b0;
        #1;
        chk("arst_hi", hi, 32'h0);
        chk("arst_lo", lo, 32'h0);
        chk("arst_busy", {31'b0, busy}, 32'h0);
        chk("arst_done", {31'b0, done}, 32'h0);
        step();
        step();
        rst_n = 1'b1;
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
